// File: rtl/nios_mul_unit.sv
// Pipelined DATA_W x DATA_W integer multiplier (MUL, MULXUU, MULXSU, MULXSS) built from four half-width partial products.
// Latency: 3 cycles, counted from the capturing edge to the edge that raises out_valid; one op per cycle.
// Backpressure: stall freezes every stage, including the output, and blocks input; flush kills all in-flight ops and wins over stall.
module nios_mul_unit #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam int H  = DATA_W / 2;
  localparam int W2 = 2 * DATA_W;

  // Operand halves, always treated as unsigned; signedness is fixed up by corr.
  logic [H-1:0]      a_lo, a_hi, b_lo, b_hi;
  logic              sign_a, sign_b;
  logic [DATA_W-1:0] pp_ll_nxt, pp_hl_nxt, pp_lh_nxt, pp_hh_nxt, corr_nxt;

  // Stage 1 state
  logic              s1_vld;
  logic [1:0]        s1_mode;
  logic [TAG_W-1:0]  s1_tag;
  logic [DATA_W-1:0] s1_pp_ll, s1_pp_hl, s1_pp_lh, s1_pp_hh, s1_corr;

  // Stage 2 state
  logic              s2_vld;
  logic [1:0]        s2_mode;
  logic [TAG_W-1:0]  s2_tag;
  logic [DATA_W-1:0] s2_hi, s2_lo;

  // Stage 3 (output) state
  logic              s3_vld;
  logic [DATA_W-1:0] s3_res;
  logic [TAG_W-1:0]  s3_tag;

  // Stage 2 combinational sums
  logic [DATA_W:0]   mid_sum;
  logic [W2-1:0]     ll_ext, mid_ext, hh_ext, prod;
  logic [DATA_W-1:0] hi_nxt, lo_nxt;

  assign a_lo = src1[H-1:0];
  assign a_hi = src1[DATA_W-1:H];
  assign b_lo = src2[H-1:0];
  assign b_hi = src2[DATA_W-1:H];

  // src1 is signed for MULXSU and MULXSS, src2 only for MULXSS.
  assign sign_a = mode[1] & src1[DATA_W-1];
  assign sign_b = mode[1] & mode[0] & src2[DATA_W-1];

  assign pp_ll_nxt = {{H{1'b0}}, a_lo} * {{H{1'b0}}, b_lo};
  assign pp_hl_nxt = {{H{1'b0}}, a_hi} * {{H{1'b0}}, b_lo};
  assign pp_lh_nxt = {{H{1'b0}}, a_lo} * {{H{1'b0}}, b_hi};
  assign pp_hh_nxt = {{H{1'b0}}, a_hi} * {{H{1'b0}}, b_hi};

  // A negative operand read as unsigned adds other<<DATA_W to the product;
  // subtracting the other operand from the high word undoes that.
  assign corr_nxt = (sign_a ? src2 : '0) + (sign_b ? src1 : '0);

  // Middle sum keeps its carry so the full 2*DATA_W product is exact.
  assign mid_sum = {1'b0, s1_pp_hl} + {1'b0, s1_pp_lh};
  assign ll_ext  = {{DATA_W{1'b0}}, s1_pp_ll};
  assign mid_ext = {{(W2-DATA_W-1){1'b0}}, mid_sum} << H;
  assign hh_ext  = {s1_pp_hh, {DATA_W{1'b0}}};
  assign prod    = ll_ext + mid_ext + hh_ext;
  assign hi_nxt  = prod[W2-1:DATA_W] - s1_corr;
  assign lo_nxt  = prod[DATA_W-1:0];

  // Valid bits: flush clears everything, stall holds, otherwise shift forward.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s3_vld <= 1'b0;
    end else if (flush) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s3_vld <= 1'b0;
    end else if (!stall) begin
      s1_vld <= in_valid;
      s2_vld <= s1_vld;
      s3_vld <= s2_vld;
    end
  end

  // Data path registers load whenever not stalled, independent of valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_mode  <= '0;
      s1_tag   <= '0;
      s1_pp_ll <= '0;
      s1_pp_hl <= '0;
      s1_pp_lh <= '0;
      s1_pp_hh <= '0;
      s1_corr  <= '0;
      s2_mode  <= '0;
      s2_tag   <= '0;
      s2_hi    <= '0;
      s2_lo    <= '0;
      s3_res   <= '0;
      s3_tag   <= '0;
    end else if (!stall) begin
      s1_mode  <= mode;
      s1_tag   <= in_tag;
      s1_pp_ll <= pp_ll_nxt;
      s1_pp_hl <= pp_hl_nxt;
      s1_pp_lh <= pp_lh_nxt;
      s1_pp_hh <= pp_hh_nxt;
      s1_corr  <= corr_nxt;
      s2_mode  <= s1_mode;
      s2_tag   <= s1_tag;
      s2_hi    <= hi_nxt;
      s2_lo    <= lo_nxt;
      s3_res   <= (s2_mode == 2'b00) ? s2_lo : s2_hi;
      s3_tag   <= s2_tag;
    end
  end

  assign out_valid = s3_vld;
  assign result    = s3_res;
  assign out_tag   = s3_tag;
  assign busy      = s1_vld | s2_vld | s3_vld;

endmodule

// File: tb/tb_nios_mul_unit.sv
// Directed bench for nios_mul_unit plus a short scoreboarded random stream.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Every comparison goes through chk, which counts checks and failures.
module tb_nios_mul_unit;
  localparam int DW = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic [1:0]    mode;
  logic [DW-1:0] src1, src2;
  logic [TW-1:0] in_tag;
  logic          stall, flush;
  logic          out_valid;
  logic [DW-1:0] result;
  logic [TW-1:0] out_tag;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  nios_mul_unit #(.DATA_W(DW), .TAG_W(TW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .mode      (mode),
    .src1      (src1),
    .src2      (src2),
    .in_tag    (in_tag),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .result    (result),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [TW-1:0] t);
    in_valid = 1'b1;
    mode     = m;
    src1     = a;
    src2     = b;
    in_tag   = t;
  endtask

  // Reference: full 64-bit product of sign- or zero-extended operands.
  function automatic logic [DW-1:0] ref_mul(input logic [1:0] m, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [63:0] ea, eb, p;
    ea = m[1] ? {{(64-DW){a[DW-1]}}, a} : {{(64-DW){1'b0}}, a};
    eb = (m == 2'b11) ? {{(64-DW){b[DW-1]}}, b} : {{(64-DW){1'b0}}, b};
    p  = ea * eb;
    return (m == 2'b00) ? p[DW-1:0] : p[2*DW-1:DW];
  endfunction

  // Single op: silent after two edges, valid after the third, gone after the fourth.
  task automatic run_single(input string name, input logic [1:0] m, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic [TW-1:0] t,
                            input logic [DW-1:0] exp);
    drive(m, a, b, t);
    step();
    in_valid = 1'b0;
    step();
    chk({name, ".early"}, 64'(out_valid), 64'd0);
    step();
    chk({name, ".vld"}, 64'(out_valid), 64'd1);
    chk({name, ".res"}, 64'(result), 64'(exp));
    chk({name, ".tag"}, 64'(out_tag), 64'(t));
    step();
    chk({name, ".done"}, 64'(out_valid), 64'd0);
  endtask

  // Pops the scoreboard for each fresh result (not a value held by stall).
  task automatic rand_observe(input logic was_stalled);
    exp_t e;
    if (out_valid && !was_stalled) begin
      if (sb.size() == 0) begin
        chk("rand.extra", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rand.res", 64'({result, out_tag}), 64'(e));
      end
    end
  endtask

  initial begin
    int   b2b_tag [8];
    logic [DW-1:0] b2b_res [8];
    int   stl_op  [10];
    logic [DW-1:0] stl_res [3];
    logic st;

    reset_n  = 1'b0;
    in_valid = 1'b0;
    mode     = 2'b00;
    src1     = '0;
    src2     = '0;
    in_tag   = '0;
    stall    = 1'b0;
    flush    = 1'b0;

    // Reset state
    step();
    step();
    chk("rst.vld",  64'(out_valid), 64'd0);
    chk("rst.res",  64'(result),    64'd0);
    chk("rst.tag",  64'(out_tag),   64'd0);
    chk("rst.busy", 64'(busy),      64'd0);
    reset_n = 1'b1;
    step();

    // Mode sweep with all-ones operands
    run_single("sweep.mul",    2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0001);
    run_single("sweep.mulxuu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
    run_single("sweep.mulxsu", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
    run_single("sweep.mulxss", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0000);

    // Most-negative operand
    run_single("neg.mulxss", 2'b11, 32'h8000_0000, 32'h0000_0002, 5'd5, 32'hFFFF_FFFF);
    run_single("neg.mulxuu", 2'b01, 32'h8000_0000, 32'h0000_0002, 5'd6, 32'h0000_0001);
    run_single("neg.mul",    2'b00, 32'h8000_0000, 32'h0000_0002, 5'd7, 32'h0000_0000);
    // MULXSU with negative src2: src2 stays unsigned -> 3*0xFFFFFFFE = 0x2_FFFFFFFA
    run_single("su.pos",     2'b10, 32'h0000_0003, 32'hFFFF_FFFE, 5'd8, 32'h0000_0002);

    // Back-to-back: ops (i+3)*(i+5) with tags 1..4, results 15,24,35,48
    b2b_tag = '{0, 0, 1, 2, 3, 4, 0, 0};
    b2b_res = '{32'd0, 32'd0, 32'd15, 32'd24, 32'd35, 32'd48, 32'd0, 32'd0};
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive(2'b00, DW'(c + 3), DW'(c + 5), TW'(c + 1));
      else       in_valid = 1'b0;
      step();
      chk("b2b.vld", 64'(out_valid), 64'(b2b_tag[c] != 0));
      if (b2b_tag[c] != 0) begin
        chk("b2b.tag", 64'(out_tag), 64'(b2b_tag[c]));
        chk("b2b.res", 64'(result),  64'(b2b_res[c]));
      end
    end

    // Stall for 2 cycles with 3 ops in flight; -1 marks no valid output
    stl_op  = '{-1, -1, 0, 0, 0, 1, 2, -1, -1, -1};
    stl_res = '{32'h0000_7000, 32'h0000_7007, 32'h0000_700E};
    for (int c = 0; c < 10; c++) begin
      if (c < 3) drive(2'b00, DW'(32'h1000 + c), 32'd7, TW'(8 + c));
      else       in_valid = 1'b0;
      stall = (c == 3) || (c == 4);
      step();
      chk("stall.vld", 64'(out_valid), 64'(stl_op[c] >= 0));
      if (stl_op[c] >= 0) begin
        chk("stall.res", 64'(result),  64'(stl_res[stl_op[c]]));
        chk("stall.tag", 64'(out_tag), 64'(8 + stl_op[c]));
      end
    end
    stall = 1'b0;

    // Flush with 2 ops in flight and a new op offered in the same cycle
    drive(2'b00, 32'd2, 32'd3, 5'd20);
    step();
    drive(2'b00, 32'd4, 32'd5, 5'd21);
    step();
    chk("flush.busy_pre", 64'(busy), 64'd1);
    drive(2'b00, 32'd6, 32'd7, 5'd22);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush.busy", 64'(busy), 64'd0);
    chk("flush.vld0", 64'(out_valid), 64'd0);
    step();
    chk("flush.vld1", 64'(out_valid), 64'd0);
    step();
    chk("flush.vld2", 64'(out_valid), 64'd0);

    // Flush wins over stall
    drive(2'b01, 32'd9, 32'd9, 5'd23);
    step();
    in_valid = 1'b0;
    stall    = 1'b1;
    flush    = 1'b1;
    step();
    stall = 1'b0;
    flush = 1'b0;
    chk("flstl.busy", 64'(busy), 64'd0);
    step();
    step();
    chk("flstl.vld", 64'(out_valid), 64'd0);

    // Asynchronous reset with 3 ops in flight
    for (int c = 0; c < 3; c++) begin
      drive(2'b00, DW'(c + 1), 32'd11, TW'(c + 1));
      step();
    end
    in_valid = 1'b0;
    chk("arst.pre", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("arst.vld",  64'(out_valid), 64'd0);
    chk("arst.res",  64'(result),    64'd0);
    chk("arst.busy", 64'(busy),      64'd0);
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("arst.after", 64'(out_valid), 64'd0);
    end

    // Random stream with random stalls against the reference model
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 4) == 0);
      mode     = 2'($urandom);
      src1     = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : DW'($urandom);
      src2     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : DW'($urandom);
      in_tag   = TW'($urandom);
      if (in_valid && !stall) sb.push_back(exp_t'{res: ref_mul(mode, src1, src2), tag: in_tag});
      st = stall;
      step();
      rand_observe(st);
    end
    in_valid = 1'b0;
    stall    = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      rand_observe(1'b0);
    end
    chk("rand.drain", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
